// File: rtl/fb_bank_scheduler.sv
// Write-port scheduler for a double-buffered framebuffer: merges the SPI stream
// and a clear engine into the back bank and swaps banks on vsync once a frame completes.
module fb_bank_scheduler #(
  parameter int WordWidth = 16,
  parameter int WordCount = 6144,
  localparam int AW = $clog2(WordCount)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [AW-1:0]        spi_addr,
  input  logic [WordWidth-1:0] spi_data,
  input  logic                 spi_wr,
  input  logic                 clear_req,
  input  logic [WordWidth-1:0] clear_color,
  input  logic                 vsync,
  output logic [AW:0]          ram_addr,
  output logic [WordWidth-1:0] ram_data,
  output logic                 ram_wr,
  output logic                 display_bank,
  output logic                 swap,
  output logic                 clear_busy,
  output logic                 frame_pending,
  output logic                 overrun
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CLEAR   = 2'd1,
    PENDING = 2'd2
  } state_t;

  localparam logic [AW-1:0] LastWord = AW'(WordCount - 1);

  state_t               state, state_n;
  logic [AW-1:0]        cnt, cnt_n;
  logic                 vsync_q;
  logic                 rise;
  logic                 frame_done;
  logic [AW:0]          addr_n;
  logic [WordWidth-1:0] data_n;
  logic                 wr_n;
  logic                 bank_n;
  logic                 swap_n;
  logic                 overrun_n;

  assign rise       = vsync & ~vsync_q;
  assign frame_done = spi_wr && (spi_addr == LastWord);

  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    addr_n    = ram_addr;
    data_n    = ram_data;
    wr_n      = 1'b0;
    bank_n    = display_bank;
    swap_n    = 1'b0;
    overrun_n = overrun;

    unique case (state)
      IDLE: begin
        if (spi_wr) begin
          wr_n   = 1'b1;
          addr_n = {~display_bank, spi_addr};
          data_n = spi_data;
        end
        if (frame_done) begin
          state_n = PENDING;
        end else if (clear_req) begin
          state_n = CLEAR;
          cnt_n   = '0;
        end
      end

      CLEAR: begin
        if (spi_wr) begin
          // SPI cannot stall, so it steals the slot and the fill counter holds
          wr_n   = 1'b1;
          addr_n = {~display_bank, spi_addr};
          data_n = spi_data;
          if (frame_done) begin
            state_n = PENDING;
            cnt_n   = '0;
          end
        end else begin
          wr_n   = 1'b1;
          addr_n = {~display_bank, cnt};
          data_n = clear_color;
          if (cnt == LastWord) begin
            state_n = IDLE;
            cnt_n   = '0;
          end else begin
            cnt_n = cnt + 1'b1;
          end
        end
      end

      PENDING: begin
        if (spi_wr) begin
          overrun_n = 1'b1;
        end
        if (rise) begin
          bank_n  = ~display_bank;
          swap_n  = 1'b1;
          state_n = IDLE;
        end
      end

      default: begin
        state_n = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      cnt          <= '0;
      vsync_q      <= 1'b1;
      ram_addr     <= '0;
      ram_data     <= '0;
      ram_wr       <= 1'b0;
      display_bank <= 1'b0;
      swap         <= 1'b0;
      overrun      <= 1'b0;
    end else begin
      state        <= state_n;
      cnt          <= cnt_n;
      vsync_q      <= vsync;
      ram_addr     <= addr_n;
      ram_data     <= data_n;
      ram_wr       <= wr_n;
      display_bank <= bank_n;
      swap         <= swap_n;
      overrun      <= overrun_n;
    end
  end

  assign clear_busy    = (state == CLEAR);
  assign frame_pending = (state == PENDING);

endmodule
